// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - turn-signal walk, hazard and brake-overlay sequencer
// Lamps light outward from bit 0; every output is registered from next-state values.
module tail_light_seq #(
  parameter int LAMPS = 3,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(LAMPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t           state, state_n, req_state;
  logic [SW-1:0]    step, step_n, req_step;
  logic [HW-1:0]    hold, hold_n;
  logic [LAMPS-1:0] lamp_l_n, lamp_r_n;
  logic             haz_req, step_end;

  function automatic logic [LAMPS-1:0] walk(input logic [SW-1:0] s);
    logic [LAMPS-1:0] p;
    for (int i = 0; i < LAMPS; i++) p[i] = (i < int'(s));
    return p;
  endfunction

  assign haz_req  = hazard | (left & right);
  assign step_end = (hold == HOLD_LAST);

  // Request decode shared by IDLE and every end-of-period decision point.
  always_comb begin
    req_state = IDLE;
    req_step  = '0;
    if (haz_req) begin
      req_state = HAZ;
      req_step  = SW'(1);
    end else if (left) begin
      req_state = LEFT;
      req_step  = SW'(1);
    end else if (right) begin
      req_state = RIGHT;
      req_step  = SW'(1);
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    hold_n  = hold;
    case (state)
      IDLE: begin
        state_n = req_state;
        step_n  = req_step;
        hold_n  = '0;
      end
      LEFT, RIGHT: begin
        if (haz_req) begin
          state_n = HAZ;
          step_n  = SW'(1);
          hold_n  = '0;
        end else if (step_end) begin
          hold_n = '0;
          if (step == '0) begin
            state_n = req_state;
            step_n  = req_step;
          end else if (step == STEP_MAX) begin
            step_n = '0;
          end else begin
            step_n = step + SW'(1);
          end
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      HAZ: begin
        if (step_end) begin
          hold_n = '0;
          if (step == '0) begin
            state_n = req_state;
            step_n  = req_step;
          end else begin
            step_n = '0;
          end
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        step_n  = '0;
        hold_n  = '0;
      end
    endcase
  end

  // Brake lights only the side that is not walking; hazard ignores it.
  always_comb begin
    lamp_l_n = '0;
    lamp_r_n = '0;
    case (state_n)
      IDLE: begin
        if (brake) begin
          lamp_l_n = '1;
          lamp_r_n = '1;
        end
      end
      LEFT: begin
        lamp_l_n = walk(step_n);
        if (brake) lamp_r_n = '1;
      end
      RIGHT: begin
        lamp_r_n = walk(step_n);
        if (brake) lamp_l_n = '1;
      end
      HAZ: begin
        if (step_n != '0) begin
          lamp_l_n = '1;
          lamp_r_n = '1;
        end
      end
      default: begin
        lamp_l_n = '0;
        lamp_r_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      step   <= '0;
      hold   <= '0;
      lamp_l <= '0;
      lamp_r <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      hold   <= hold_n;
      lamp_l <= lamp_l_n;
      lamp_r <= lamp_r_n;
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - three-configuration bench against a period/phase reference model
// Model tracks mode plus elapsed cycles within the current period, not step/hold.
module tb_tail_light_seq;

  logic clk = 1'b0;
  logic reset, left, right, hazard, brake;
  logic [2:0] l0, r0, l1, r1;
  logic [4:0] l2, r2;
  logic b0, b1, b2;

  always #5 clk = ~clk;

  tail_light_seq #(.LAMPS(3), .HOLD(1)) u0 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .lamp_l(l0), .lamp_r(r0), .busy(b0));
  tail_light_seq #(.LAMPS(3), .HOLD(2)) u1 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .lamp_l(l1), .lamp_r(r1), .busy(b1));
  tail_light_seq #(.LAMPS(5), .HOLD(1)) u2 (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .lamp_l(l2), .lamp_r(r2), .busy(b2));

  int n_tests = 0;
  int n_fail  = 0;

  // mode: 0 idle, 1 left, 2 right, 3 hazard; t = cycles elapsed in current period
  int lamps_p[3] = '{3, 3, 5};
  int hold_p[3]  = '{1, 2, 1};
  int mode[3];
  int t[3];
  int exp_l[3], exp_r[3], exp_b[3];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int per, lit, ones;
    bit haz;
    haz  = hazard | (left & right);
    ones = (1 << lamps_p[k]) - 1;
    per  = (mode[k] == 3) ? 2 * hold_p[k] : (lamps_p[k] + 1) * hold_p[k];
    if (!reset) begin
      mode[k] = 0;
      t[k]    = 0;
    end else if (mode[k] == 0 || (mode[k] != 3 && haz) || t[k] == per - 1) begin
      t[k]    = 0;
      mode[k] = haz ? 3 : left ? 1 : right ? 2 : 0;
    end else begin
      t[k]++;
    end
    lit = ((t[k] / hold_p[k]) + 1) % (lamps_p[k] + 1);
    exp_l[k] = 0;
    exp_r[k] = 0;
    case (mode[k])
      1: exp_l[k] = (1 << lit) - 1;
      2: exp_r[k] = (1 << lit) - 1;
      3: if (t[k] < hold_p[k]) begin exp_l[k] = ones; exp_r[k] = ones; end
      default: ;
    endcase
    if (reset && brake) begin
      if (mode[k] == 0 || mode[k] == 2) exp_l[k] = ones;
      if (mode[k] == 0 || mode[k] == 1) exp_r[k] = ones;
    end
    exp_b[k] = (mode[k] != 0);
  endtask

  task automatic cycle(input bit rs, input bit l, input bit r, input bit h, input bit b);
    reset = rs; left = l; right = r; hazard = h; brake = b;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check("u0.lamp_l", int'(l0), exp_l[0]);
    check("u0.lamp_r", int'(r0), exp_r[0]);
    check("u0.busy",   int'(b0), exp_b[0]);
    check("u1.lamp_l", int'(l1), exp_l[1]);
    check("u1.lamp_r", int'(r1), exp_r[1]);
    check("u1.busy",   int'(b1), exp_b[1]);
    check("u2.lamp_l", int'(l2), exp_l[2]);
    check("u2.lamp_r", int'(r2), exp_r[2]);
    check("u2.busy",   int'(b2), exp_b[2]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin mode[k] = 0; t[k] = 0; end
    // reset held with left and brake asserted, then a continuous left walk
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
    check("reset.lamp_l", int'(l0), 0);
    check("reset.busy", int'(b0), 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
    check("walk.lamp_l_wrap", int'(l0), 1);
    // single left pulse, then idle long enough for every config to finish
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0);
    // right walk preempted by hazard at step 2
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0);
    check("preempt.lamp_l", int'(l0), 7);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
    // brake with left walk, idle brake, hazard brake, left&right
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0);
    // mid-walk side switch on the wide config
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0);
    // randomized inputs held for random spans
    for (int i = 0; i < 300; i++) begin
      bit rs, l, r, h, b;
      int span;
      rs = ($urandom_range(0, 39) != 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 3) == 0);
      span = $urandom_range(1, 8);
      for (int j = 0; j < span; j++) cycle(rs, l, r, h, b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised turn-signal and brake-lamp sequencer for the tail-light controller. It drives LAMPS lamps per side, with lamps lighting outward in a sequential "walk". It adds hazard mode, a brake overlay and a programmable per-step hold time. This block replaces the fixed 3-lamp, left/right-only light FSM. It sits between the debounced driver controls and the lamp drivers.

## Interface
- LAMPS, 3: lamps per side; legal range 2..8.
- HOLD, 1: clock cycles each step is held; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- left  in  1  left-turn request, level-sensitive.
- right  in  1  right-turn request, level-sensitive.
- hazard  in  1  hazard request, level-sensitive.
- brake  in  1  brake pedal, level-sensitive.
- lamp_l  out  LAMPS  left lamps; bit 0 is innermost.
- lamp_r  out  LAMPS  right lamps; bit 0 is innermost.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, LEFT, RIGHT, HAZ.
- Effective hazard request: haz_req = hazard | (left & right).
- Request priority at every decision point: haz_req, then left, then right, then none.
- Counters:
  - step: width $clog2(LAMPS+1).
  - hold: width $clog2(HOLD+1); it counts 0..HOLD-1.
- A step ends on the cycle where hold == HOLD-1. At that edge, hold clears and step advances. Otherwise hold increments.
- IDLE:
  - Both walk patterns are off. Requests are evaluated every cycle.
  - haz_req: go to HAZ with step=1.
  - left: go to LEFT with step=1.
  - right: go to RIGHT with step=1.
  - Entering any mode clears hold.
- LEFT / RIGHT:
  - The active side shows the low `step` bits set: step 1 gives 0..001, step LAMPS gives all ones, step 0 gives all zeros.
  - Step order is 1, 2, …, LAMPS, 0.
  - At the end of step 0, re-evaluate requests using the IDLE rules. With no request, go to IDLE.
  - left/right changes mid-walk are ignored, so a started walk always completes.
  - Exception: haz_req preempts immediately. It is sampled on any cycle and the next state is HAZ with step=1 and hold=0.
- HAZ:
  - Two phases: step 1 lights all lamps on both sides; step 0 turns all lamps off.
  - At the end of step 0, re-evaluate requests using the IDLE rules.
  - Dropping haz_req mid-phase is ignored until that decision point.
- Brake overlay:
  - In IDLE, brake drives both sides to all ones.
  - In LEFT, brake drives lamp_r to all ones. In RIGHT, brake drives lamp_l to all ones.
  - The walking side is never overridden by brake.
  - In HAZ, brake has no effect.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Reset:
  - While reset==0 at a rising edge, the next state is IDLE, with step=0 and hold=0.
  - Outputs after reset: lamp_l=0, lamp_r=0, busy=0.
  - Reset mid-walk aborts the walk with no completion.
  - During reset cycles, brake is not applied.
- Latency: an input sampled at edge N affects the outputs from edge N+1.
  - Example: left is high before edge N in IDLE. Then lamp_l=0..001 and busy=1 are visible after edge N.
- Walk period is (LAMPS+1)*HOLD cycles. Hazard period is 2*HOLD cycles.
- Continuous left with HOLD=1, LAMPS=3: lamp_l cycles 001, 011, 111, 000 and repeats, with no IDLE cycle between periods.
- Hazard preemption:
  - haz_req is sampled at any edge in LEFT/RIGHT.
  - Both sides are all ones from the next cycle, for HOLD cycles.
- Simultaneous left & right at a decision point is treated as a hazard.
- Returning to IDLE: busy falls at the same edge the state enters IDLE.

## Test plan
- **Reset:** LAMPS=3, HOLD=1, left=1 held, reset=0 for 3 cycles -> lamp_l=000, lamp_r=000, busy=0. Release reset -> lamp_l=001 on the first edge after release, then 011, 111, 000, 001.
- **Single left pulse:** HOLD=2, left=1 for one cycle only -> lamp_l is 001,001,011,011,111,111,000,000, then IDLE with busy=0 (8 busy cycles).
- **Hazard preemption:** HOLD=1, right walk at step 2 (lamp_r=011), assert hazard -> next cycle lamp_l=111 and lamp_r=111, then 000/000. Deassert hazard -> IDLE.
- **Brake overlay:** LAMPS=3, left walk with brake=1 -> lamp_r=111 throughout and lamp_l walks normally. In IDLE with brake=1 -> both 111. In HAZ with brake=1 -> both alternate 111/000.
- **Left & right together:** left and right asserted together from IDLE -> identical to hazard behaviour (111/111, 000/000).
- **Width generality:** LAMPS=5, HOLD=1, right held -> lamp_r cycles 00001, 00011, 00111, 01111, 11111, 00000 with period 6. Mid-walk switch from right to left -> the switch takes effect only after the 00000 step.
